// File: rtl/id_decode_stage_pkg.sv
// Shared decode constants, opcodes and the decoded-bundle type for id_decode_stage.
// The M-extension ALU codes exist only when ID_MEXT_EN is defined.
package id_decode_stage_pkg;

    localparam int INST_TYPE_WIDTH = 3;
    localparam int ALU_TYPE_WIDTH  = 5;
    localparam int REG_NUM         = 5;

    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_NONE = 3'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_R    = 3'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_I    = 3'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_S    = 3'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_B    = 3'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_U    = 3'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_J    = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLL  = 5'd3;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLT  = 5'd4;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLTU = 5'd5;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_XOR  = 5'd6;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SRL  = 5'd7;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SRA  = 5'd8;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_OR   = 5'd9;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_AND  = 5'd10;
`ifdef ID_MEXT_EN
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MUL    = 5'd11;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MULH   = 5'd12;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MULHSU = 5'd13;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MULHU  = 5'd14;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_DIV    = 5'd15;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_DIVU   = 5'd16;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_REM    = 5'd17;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_REMU   = 5'd18;
`endif

    // Immediate is kept at 32 bits; the stage sign-extends it to XLEN at the output.
    typedef struct packed {
        logic                       illegal;
        logic [INST_TYPE_WIDTH-1:0] inst_type;
        logic [ALU_TYPE_WIDTH-1:0]  alu_type;
        logic                       wr;
        logic                       imm_tag;
        logic [31:0]                imm;
        logic [REG_NUM-1:0]         rd;
        logic [REG_NUM-1:0]         rs1;
        logic [REG_NUM-1:0]         rs2;
    } dec_t;

    function automatic dec_t dec_ok(input logic [INST_TYPE_WIDTH-1:0] t,
                                    input logic [ALU_TYPE_WIDTH-1:0] a,
                                    input logic w, input logic it, input logic [31:0] imm,
                                    input logic [REG_NUM-1:0] rd, input logic [REG_NUM-1:0] rs1,
                                    input logic [REG_NUM-1:0] rs2);
        dec_t d;
        d.illegal   = 1'b0;
        d.inst_type = t;
        d.alu_type  = a;
        d.wr        = w;
        d.imm_tag   = it;
        d.imm       = imm;
        d.rd        = rd;
        d.rs1       = rs1;
        d.rs2       = rs2;
        return d;
    endfunction

    function automatic dec_t dec_illegal();
        dec_t d;
        d         = '0;
        d.illegal = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/id_inst_fifo.sv
// Synchronous instruction buffer with wrap-bit pointers and a synchronous flush.
module id_inst_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[AddrW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/id_decode_stage.sv
// Pipelined RV32I decode stage: instruction FIFO, combinational decode, registered output slot.
// Define ID_MEXT_EN to decode the M-extension R-type encodings.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [INST_TYPE_WIDTH-1:0] inst_type,
    output logic [ALU_TYPE_WIDTH-1:0]  alu_type,
    output logic                       write_alu_result_tag,
    output logic                       imm_tag,
    output logic [XLEN-1:0]            extended_imm,
    output logic [REG_NUM-1:0]         rd,
    output logic [REG_NUM-1:0]         rs1,
    output logic [REG_NUM-1:0]         rs2,
    output logic                       illegal
);

    localparam int unsigned EntryW = 32 + PC_WIDTH;

    function automatic logic [ALU_TYPE_WIDTH-1:0] base_alu(input logic [2:0] f3);
        logic [ALU_TYPE_WIDTH-1:0] a;
        unique case (f3)
            3'b000:  a = ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t                      d;
        logic [6:0]                f7, shift_hi;
        logic [2:0]                f3;
        logic [4:0]                f_rd, f_rs1, f_rs2;
        logic [31:0]               i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
        logic [ALU_TYPE_WIDTH-1:0] alu;
        f7    = inst[31:25];
        f3    = inst[14:12];
        f_rd  = inst[11:7];
        f_rs1 = inst[19:15];
        f_rs2 = inst[24:20];
        i_imm = {{20{inst[31]}}, inst[31:20]};
        s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        u_imm = {inst[31:12], 12'b0};
        j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        // RV64 shifts borrow inst[25] as shamt[5], so it is excluded from the funct check
        shift_hi = (XLEN == 64) ? {inst[31:26], 1'b0} : inst[31:25];
        shamt    = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
        alu      = ALU_NOP;
        d        = dec_illegal();
        case (inst[6:0])
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    alu = base_alu(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    alu = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    alu = ALU_SRA;
                end
`ifdef ID_MEXT_EN
                else if (f7 == F7_MEXT) begin
                    unique case (f3)
                        3'b000:  alu = ALU_MUL;
                        3'b001:  alu = ALU_MULH;
                        3'b010:  alu = ALU_MULHSU;
                        3'b011:  alu = ALU_MULHU;
                        3'b100:  alu = ALU_DIV;
                        3'b101:  alu = ALU_DIVU;
                        3'b110:  alu = ALU_REM;
                        default: alu = ALU_REMU;
                    endcase
                end
`endif
                if (alu != ALU_NOP) d = dec_ok(INST_TYPE_R, alu, 1'b1, 1'b0, '0, f_rd, f_rs1, f_rs2);
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL) begin
                    if (shift_hi == F7_BASE) alu = ALU_SLL;
                end else if (f3 == F3_SR) begin
                    if (shift_hi == F7_BASE)     alu = ALU_SRL;
                    else if (shift_hi == F7_ALT) alu = ALU_SRA;
                end else begin
                    alu = base_alu(f3);
                end
                if (alu != ALU_NOP) begin
                    d = dec_ok(INST_TYPE_I, alu, 1'b1, 1'b1,
                               (f3 == F3_SLL || f3 == F3_SR) ? shamt : i_imm, f_rd, f_rs1, '0);
                end
            end
            OPC_LOAD, OPC_JALR: d = dec_ok(INST_TYPE_I, ALU_ADD, 1'b1, 1'b1, i_imm, f_rd, f_rs1, '0);
            OPC_STORE: d = dec_ok(INST_TYPE_S, ALU_ADD, 1'b0, 1'b1, s_imm, '0, f_rs1, f_rs2);
            OPC_BRANCH: begin
                case (f3)
                    F3_BEQ, F3_BNE:   alu = ALU_SUB;
                    F3_BLT, F3_BGE:   alu = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu = ALU_SLTU;
                    default:          alu = ALU_NOP;
                endcase
                if (alu != ALU_NOP) d = dec_ok(INST_TYPE_B, alu, 1'b0, 1'b0, b_imm, '0, f_rs1, f_rs2);
            end
            OPC_LUI, OPC_AUIPC: d = dec_ok(INST_TYPE_U, ALU_ADD, 1'b1, 1'b1, u_imm, f_rd, '0, '0);
            OPC_JAL:   d = dec_ok(INST_TYPE_J, ALU_ADD, 1'b1, 1'b1, j_imm, f_rd, '0, '0);
            default:   d = dec_illegal();
        endcase
        return d;
    endfunction

    logic              fifo_full, fifo_empty, push, load;
    logic [EntryW-1:0] head;
    dec_t              head_dec, dec_q;
    logic              out_valid_d, out_valid_q;
    logic [PC_WIDTH-1:0] out_pc_q;

    id_inst_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({in_inst, in_pc}),
        .pop   (load),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign load     = (!out_valid_q || out_ready) && !fifo_empty;
    assign head_dec = decode(head[EntryW-1 -: 32]);

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (load)      out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            dec_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load && !flush) begin
                out_pc_q <= head[PC_WIDTH-1:0];
                dec_q    <= head_dec;
            end
        end
    end

    assign out_valid            = out_valid_q;
    assign out_pc               = out_pc_q;
    assign inst_type            = dec_q.inst_type;
    assign alu_type             = dec_q.alu_type;
    assign write_alu_result_tag = dec_q.wr;
    assign imm_tag              = dec_q.imm_tag;
    assign extended_imm         = XLEN'($signed(dec_q.imm));
    assign rd                   = dec_q.rd;
    assign rs1                  = dec_q.rs1;
    assign rs2                  = dec_q.rs2;
    assign illegal              = dec_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed cases plus random traffic vs a queue model.
module tb_id_decode_stage;
    import id_decode_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int PW    = 32;
    localparam int DEPTH = 2;

    logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [PW-1:0] in_pc, out_pc;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [ALU_TYPE_WIDTH-1:0] alu_type;
    logic write_alu_result_tag, imm_tag, illegal;
    logic [XLEN-1:0] extended_imm;
    logic [REG_NUM-1:0] rd, rs1, rs2;

    id_decode_stage #(.XLEN(XLEN), .PC_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .inst_type(inst_type), .alu_type(alu_type),
        .write_alu_result_tag(write_alu_result_tag), .imm_tag(imm_tag),
        .extended_imm(extended_imm), .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit     illegal;
        int     itype;
        int     alu;
        bit     wr;
        bit     immt;
        longint imm;
        int     rd;
        int     rs1;
        int     rs2;
    } exp_t;

    typedef struct {
        logic [31:0]   inst;
        logic [PW-1:0] pc;
    } txn_t;

    function automatic exp_t fill(input int t, input int a, input bit w, input bit it,
                                  input longint imm, input int d, input int s1, input int s2);
        exp_t e;
        e.illegal = 1'b0;
        e.itype   = t;
        e.alu     = a;
        e.wr      = w;
        e.immt    = it;
        e.imm     = imm;
        e.rd      = d;
        e.rs1     = s1;
        e.rs2     = s2;
        return e;
    endfunction

    // Reference decode built from the ISA field rules using signed arithmetic.
    function automatic exp_t model(input logic [31:0] inst);
        exp_t   e;
        longint s, imm;
        int     f3, f7, d, s1, s2, al;
        int     base[8];
        int     m_alu[8];
        base = '{int'(ALU_ADD), int'(ALU_SLL), int'(ALU_SLT), int'(ALU_SLTU),
                 int'(ALU_XOR), int'(ALU_SRL), int'(ALU_OR), int'(ALU_AND)};
`ifdef ID_MEXT_EN
        m_alu = '{int'(ALU_MUL), int'(ALU_MULH), int'(ALU_MULHSU), int'(ALU_MULHU),
                  int'(ALU_DIV), int'(ALU_DIVU), int'(ALU_REM), int'(ALU_REMU)};
`else
        m_alu = '{default: -1};
`endif
        s  = longint'($signed(inst));
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        d  = int'(inst[11:7]);
        s1 = int'(inst[19:15]);
        s2 = int'(inst[24:20]);
        e  = fill(int'(INST_TYPE_NONE), int'(ALU_NOP), 0, 0, 0, 0, 0, 0);
        e.illegal = 1'b1;
        case (inst[6:0])
            7'h33: begin
                al = -1;
                if (f7 == 0) al = base[f3];
                else if (f7 == 32 && f3 == 0) al = int'(ALU_SUB);
                else if (f7 == 32 && f3 == 5) al = int'(ALU_SRA);
                else if (f7 == 1) al = m_alu[f3];
                if (al >= 0) e = fill(int'(INST_TYPE_R), al, 1, 0, 0, d, s1, s2);
            end
            7'h13: begin
                al  = -1;
                imm = longint'(inst[24:20]);
                if (f3 == 1) begin
                    if (f7 == 0) al = int'(ALU_SLL);
                end else if (f3 == 5) begin
                    if (f7 == 0) al = int'(ALU_SRL);
                    else if (f7 == 32) al = int'(ALU_SRA);
                end else begin
                    al  = base[f3];
                    imm = s >>> 20;
                end
                if (al >= 0) e = fill(int'(INST_TYPE_I), al, 1, 1, imm, d, s1, 0);
            end
            7'h03, 7'h67: e = fill(int'(INST_TYPE_I), int'(ALU_ADD), 1, 1, s >>> 20, d, s1, 0);
            7'h23: begin
                imm = ((s >>> 25) * 32) + longint'(inst[11:7]);
                e = fill(int'(INST_TYPE_S), int'(ALU_ADD), 0, 1, imm, 0, s1, s2);
            end
            7'h63: begin
                imm = ((s >>> 31) * 4096) + longint'(inst[7]) * 2048 +
                      longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (f3 < 2)      al = int'(ALU_SUB);
                else if (f3 < 4) al = -1;
                else if (f3 < 6) al = int'(ALU_SLT);
                else             al = int'(ALU_SLTU);
                if (al >= 0) e = fill(int'(INST_TYPE_B), al, 0, 0, imm, 0, s1, s2);
            end
            7'h37, 7'h17: e = fill(int'(INST_TYPE_U), int'(ALU_ADD), 1, 1, (s >>> 12) * 4096, d, 0, 0);
            7'h6F: begin
                imm = ((s >>> 31) * 1048576) + longint'(inst[19:12]) * 4096 +
                      longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                e = fill(int'(INST_TYPE_J), int'(ALU_ADD), 1, 1, imm, d, 0, 0);
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs[9];
        logic [31:0] r;
        int          sel;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r    = $urandom();
        sel  = $urandom_range(0, 10);
        if (sel < 9) r[6:0] = opcs[sel];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    localparam logic [63:0] IMM_MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;

    txn_t q[$];
    txn_t t;
    exp_t e_mon;
    bit   mon_en = 1'b0;

    // Scoreboard: everything accepted and not flushed leaves in order with its decode.
    always @(negedge clk) begin
        if (mon_en) begin
            check("sb_in_ready", in_ready, (q.size() - int'(out_valid)) < DEPTH);
            if (out_valid && out_ready) begin
                check("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    t     = q.pop_front();
                    e_mon = model(t.inst);
                    check("sb_pc", out_pc, t.pc);
                    check("sb_illegal", illegal, e_mon.illegal);
                    check("sb_type", inst_type, e_mon.itype);
                    check("sb_alu", alu_type, e_mon.alu);
                    check("sb_wr", write_alu_result_tag, e_mon.wr);
                    check("sb_immtag", imm_tag, e_mon.immt);
                    check("sb_imm", extended_imm, e_mon.imm & IMM_MASK);
                    check("sb_rd", rd, e_mon.rd);
                    check("sb_rs1", rs1, e_mon.rs1);
                    check("sb_rs2", rs2, e_mon.rs2);
                end
            end
            if (flush) q.delete();
            if (in_valid && in_ready && !flush) q.push_back('{in_inst, in_pc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_single(input logic [31:0] inst, input logic [31:0] pc, input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat0"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_pc"}, out_pc, pc);
    endtask

    task automatic push_wait(input logic [31:0] inst, input logic [31:0] pc, input string tag);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_accept"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu", alu_type, ALU_NOP);
        check("rst_type", inst_type, INST_TYPE_NONE);
        check("rst_imm", extended_imm, 0);
        check("rst_illegal", illegal, 0);
        mon_en = 1'b1;
        tick();

        send_single(32'h0050_0093, 32'h100, "addi");
        check("addi_alu", alu_type, ALU_ADD);
        check("addi_immtag", imm_tag, 1);
        check("addi_imm", extended_imm, 5);
        check("addi_rd", rd, 1);
        check("addi_rs1", rs1, 0);
        tick();

        send_single(32'h4020_8133, 32'h104, "sub");
        check("sub_alu", alu_type, ALU_SUB);
        check("sub_rd", rd, 2);
        check("sub_rs1", rs1, 1);
        check("sub_rs2", rs2, 2);
        check("sub_immtag", imm_tag, 0);
        tick();

        send_single(32'hFE20_AE23, 32'h108, "sw");
        check("sw_type", inst_type, INST_TYPE_S);
        check("sw_imm", extended_imm, 32'hFFFF_FFFC);
        check("sw_wr", write_alu_result_tag, 0);
        tick();

        send_single(32'h0220_81B3, 32'h10C, "mul");
`ifdef ID_MEXT_EN
        check("mul_alu", alu_type, ALU_MUL);
        check("mul_rd", rd, 3);
        check("mul_illegal", illegal, 0);
`else
        check("mul_illegal", illegal, 1);
        check("mul_alu", alu_type, ALU_NOP);
        check("mul_wr", write_alu_result_tag, 0);
`endif
        tick();

        // Back-pressure: three entries fit (slot + two buffered), then in_ready drops.
        out_ready = 1'b0;
        push_wait(32'h0010_0093, 32'h200, "stall_a");
        push_wait(32'h0020_0113, 32'h204, "stall_b");
        push_wait(32'h0030_0193, 32'h208, "stall_c");
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_hold_pc", out_pc, 32'h200);
        check("stall_hold_valid", out_valid, 1);
        tick();
        in_valid = 1'b1; in_inst = 32'h0040_0213; in_pc = 32'h20C;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_blocked", in_ready, 0);
            check("stall_hold2_pc", out_pc, 32'h200);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_a", out_pc, 32'h200);
        @(negedge clk);
        check("drain_b", out_pc, 32'h204);
        check("drain_b_valid", out_valid, 1);
        @(negedge clk);
        check("drain_c", out_pc, 32'h208);
        check("drain_c_valid", out_valid, 1);
        @(negedge clk);
        check("drain_done", out_valid, 0);
        tick();

        // Flush while full, with a simultaneous offer that must be dropped.
        out_ready = 1'b0;
        push_wait(32'h0050_0293, 32'h300, "fl_a");
        push_wait(32'h0060_0313, 32'h304, "fl_b");
        push_wait(32'h0070_0393, 32'h308, "fl_c");
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0080_0413; in_pc = 32'h30C;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("flush_quiet", out_valid, 0);
        end
        tick();

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_inst   = rand_inst();
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        @(negedge clk);
        check("final_drain", q.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Parametrised, pipelined instruction-decode stage. Buffers fetched instructions in a small FIFO and decodes every RV32I base format (R/I/S/B/U/J) into the existing ALU control bundle plus the full sign-extended immediate. Presents the result in a registered output slot with valid/ready flow control. Sits between the fetch unit and the register-read/issue logic, replacing the purely combinational R/I-only decoder.

## Interface

Parameters:
- `XLEN`, 32: datapath and immediate width; 32 or 64.
- `PC_WIDTH`, 32: width of the carried program counter.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of all buffered and output state.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  buffer can accept.
- `in_inst`  in  32  raw instruction.
- `in_pc`  in  PC_WIDTH  its PC.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  consumer takes the bundle.
- `out_pc`  out  PC_WIDTH  carried PC.
- `inst_type`  out  `INST_TYPE_WIDTH`  R/I/S/B/U/J/NONE.
- `alu_type`  out  `ALU_TYPE_WIDTH`  ALU operation.
- `write_alu_result_tag`  out  1  rd is written.
- `imm_tag`  out  1  operand B is the immediate.
- `extended_imm`  out  XLEN  sign-extended immediate.
- `rd`, `rs1`, `rs2`  out  `REG_NUM` each  register indices; 0 when unused by the format.
- `illegal`  out  1  unrecognised opcode/funct.

## Operation

- Accept on `in_valid && in_ready`. Write `{in_inst, in_pc}` at the FIFO tail. `in_ready = !full`, independent of `in_valid`.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full when the indices match and the wrap bits differ; empty when both match. Pointers wrap naturally.
- Decode operates on the FIFO head combinationally. The output slot loads when `!out_valid || out_ready` and the FIFO is non-empty. Loading pops the head.
- Decoding by opcode:
  - R (0110011): funct7/funct3 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. `imm_tag` 0. `extended_imm` 0.
  - I-ALU (0010011): ADDI/SLTI/SLTIU/XORI/ORI/ANDI. SLLI/SRLI/SRAI take shamt from imm[4:0] (imm[5:0] when XLEN=64). Any other upper bits are illegal.
  - LOAD (0000011) and JALR (1100111): I-format, ALU_ADD, imm_tag 1.
  - STORE (0100011): S-format, ALU_ADD, write tag 0, rs1/rs2 valid.
  - BRANCH (1100011): B-format, imm bit0=0. ALU_SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU. Write tag 0. funct3 010/011 is illegal.
  - LUI (0110111) and AUIPC (0010111): U-format, imm = inst[31:12]<<12 sign-extended, ALU_ADD.
  - JAL (1101111): J-format, ALU_ADD, write tag 1.
- Illegal encodings: `illegal`=1, `alu_type`=ALU_NOP, `write_alu_result_tag`=0, `imm_tag`=0, `inst_type`=NONE. The bundle still flows with its PC.
- All immediates are sign-extended from bit 31 to XLEN.

## Timing

- Reset, asynchronous: FIFO empty, pointers 0, `out_valid` 0. Every other output register is 0; `alu_type` resets to ALU_NOP and `inst_type` to NONE. `in_ready` reads 1 once `rst` deasserts.
- Latency: an instruction accepted at edge N into an empty buffer is decoded on the output at edge N+1. Minimum latency is 1 cycle.
- Throughput is 1 per cycle with `out_ready` held high.
- The output holds stable while `out_valid && !out_ready`. When full, push and pop never occur together, because `in_ready`=0.
- `flush` at edge N empties the FIFO and clears `out_valid`. An accept in the same cycle is discarded. `in_ready`=1 after edge N.
- `rst` asserted mid-transfer drops all state immediately, without waiting for a clock edge.

## Configuration

- `ID_MEXT_EN`, defined: R-type with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to the matching ALU_MUL… codes.
- Undefined: those encodings set `illegal`=1, and the M-extension ALU codes are not compiled.

## Structure

- The shared `define.h` gains:
  - INST_TYPE_WIDTH and the INST_TYPE_{R,I,S,B,U,J,NONE} codes;
  - the LOAD/STORE/BRANCH/LUI/AUIPC/JAL/JALR opcodes;
  - the shift and branch funct3 values;
  - the ALU_MUL…ALU_REMU codes, guarded by `ID_MEXT_EN`.
- Sub-module `id_inst_fifo`: parametrised synchronous FIFO (push/pop/full/empty/flush).
- Decode logic lives in the top-level as combinational functions feeding the output register.

## Test plan

- Reset, then `0x00500093` (addi x1,x0,5) → one cycle later: `out_valid`, ALU_ADD, `imm_tag`=1, `extended_imm`=5, `rd`=1, `rs1`=0.
- `0x40208133` (sub x2,x1,x2) → ALU_SUB, `rd`=2, `rs1`=1, `rs2`=2, `imm_tag`=0.
- `0xFE20AE23` (sw x2,-4(x1)) → inst_type S, `extended_imm`=0xFFFFFFFC, `write_alu_result_tag`=0.
- `out_ready`=0 with 3 pushes at FIFO_DEPTH=2 → `in_ready` falls after the 2nd buffered entry. Output holds the 1st instruction. Release → three bundles in order, one per cycle.
- `flush` asserted together with `in_valid` while the FIFO is full → next cycle `out_valid`=0, empty, `in_ready`=1. The flushed instruction never appears.
- `0x022081B3` (mul x3,x1,x2) → with `ID_MEXT_EN`: ALU_MUL, `rd`=3. Without it: `illegal`=1, ALU_NOP, write tag 0.
